intc_irq_src: RTL and testbench
===============================

INTC_IRQ_SRC -- requirements
Module: intc_irq_src

Interface
REQ-001 The block SHALL have these ports (name direction width meaning), clock and reset first:
REQ-002 clk  input  1  clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 en  input  1  source enable; 0 withdraws and blocks requests.
REQ-005 event_in  input  1  peripheral event, one event per cycle high.
REQ-006 prio_in  input  4  configured priority, higher value means more urgent.
REQ-007 thresh  input  4  coalescing threshold; 0 is treated as 1.
REQ-008 irq_ack  input  1  controller accepted the request.
REQ-009 irq_eoi  input  1  end-of-interrupt from the handler.
REQ-010 clr_ovf  input  1  clears the sticky overflow flag.
REQ-011 irq_req  output  1  interrupt request to the controller.
REQ-012 irq_prio  output  4  priority attached to the request.
REQ-013 pending_cnt  output  4  uncollected event count.
REQ-014 served_cnt  output  4  events consumed by the last acknowledge.
REQ-015 overflow  output  1  sticky flag: an event was lost to saturation.
REQ-016 in_service  output  1  high while in the SERVICE state.

Function
REQ-017 The FSM SHALL have three states: IDLE, REQ and SERVICE.
REQ-018 The outputs irq_req and in_service SHALL be registered Moore outputs:
- irq_req = (state == REQ).
- in_service = (state == SERVICE).
REQ-019 Event counting SHALL work as follows:
- pending_cnt increments by 1 on each clock edge where event_in = 1.
- It saturates at 15.
REQ-020 If event_in = 1 while pending_cnt = 15, pending_cnt SHALL stay at 15 and overflow SHALL be set.
REQ-021 If a set and clr_ovf occur in the same cycle, the set SHALL win.
REQ-022 IDLE -> REQ SHALL occur when en = 1 and pending_cnt >= max(thresh, 1), using the registered count.
- On that edge, prio_in is latched into irq_prio.
REQ-023 Latency SHALL be fixed: for an event sampled at edge E0 with thresh <= 1, irq_req is high after edge E0+1.
REQ-024 In REQ, irq_req and irq_prio SHALL hold stable until irq_ack; prio_in changes are ignored.
REQ-025 REQ -> SERVICE SHALL occur on irq_ack = 1, with these updates on the same edge:
- served_cnt <= pending_cnt.
- pending_cnt <= event_in (0 or 1).
REQ-026 REQ -> IDLE SHALL occur when en = 0 and irq_ack = 0.
- The request is withdrawn and pending_cnt is retained.
- If en = 0 and irq_ack = 1 in the same cycle, the ack wins.
REQ-027 SERVICE -> IDLE SHALL occur on irq_eoi = 1.
- Events arriving during SERVICE accumulate.
- A new request may be raised from the cycle after the return to IDLE.
REQ-028 irq_ack outside REQ and irq_eoi outside SERVICE SHALL be ignored.
REQ-029 A thresh value changed while in REQ SHALL NOT withdraw the request.
REQ-030 The width rule SHALL be: all counts are 4-bit unsigned, and the threshold compare is unsigned.

Reset
REQ-031 On rst, the block SHALL immediately set:
- state = IDLE.
- irq_req = 0, in_service = 0, overflow = 0.
- pending_cnt = 0, served_cnt = 0, irq_prio = 0.
REQ-032 When rst asserts in REQ or SERVICE, the block SHALL abort without emitting ack or eoi side effects.
REQ-033 Events are lost on reset.

Structure
REQ-034 The state encodings (IDLE=2'b00, REQ=2'b01, SERVICE=2'b10) and the count width constant (4) SHALL reside in the shared package intc_pkg.
REQ-035 The saturating event counter with overflow flag SHALL be a sub-module, intc_sat_cnt.
- Ports: clk, rst, inc, load, load_val, cnt, sat.
- The FSM and the output registers remain in intc_irq_src.

Verification
REQ-036 The bench SHALL cover these directed scenarios:
- thresh=3, en=1, prio_in=5, three single-cycle events -> pending_cnt=3; irq_req high one edge later with irq_prio=5; ack -> served_cnt=3, pending_cnt=0, in_service=1.
- In REQ, change prio_in 5->9, then ack -> irq_prio stays 5 throughout REQ.
- Event coincident with irq_ack while pending_cnt=4 -> served_cnt=4, pending_cnt=1.
- 17 consecutive events in SERVICE -> pending_cnt=15, overflow=1; clr_ovf together with an event at 15 -> overflow stays 1; clr_ovf alone -> overflow=0.
- In REQ, drop en -> irq_req=0 next edge, state IDLE, pending_cnt retained; re-raise en -> irq_req high next edge.
- Assert rst mid-SERVICE -> all outputs 0 immediately; a later irq_eoi is ignored and irq_req stays 0.

Source files
------------

// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt-source slice.
//   state_t     : FSM encoding of an interrupt source (IDLE / REQ / SERVICE).
//   CNT_W       : width of every event count and of the threshold.
//   CNT_MAX     : saturation value of the event counter.
//   eff_thresh(): threshold as used by the compare (0 behaves like 1).
package intc_pkg;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_REQ     = 2'b01,
    ST_SERVICE = 2'b10
  } state_t;

  // A zero threshold would fire with no events pending; clamp it to one.
  function automatic logic [CNT_W-1:0] eff_thresh(input logic [CNT_W-1:0] t);
    return (t == '0) ? CNT_W'(1) : t;
  endfunction

endpackage

// File: rtl/intc_sat_cnt.sv
// Saturating event counter for an interrupt source.
//   clk, rst  : clock, asynchronous active-high reset
//   inc       : count one event this cycle
//   load      : replace the count with load_val (takes priority over inc)
//   load_val  : value loaded when load is high
//   cnt       : current count, saturates at CNT_MAX
//   sat       : high when an increment is lost because cnt is at CNT_MAX
module intc_sat_cnt
  import intc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  // A load absorbs the coincident event through load_val, so nothing is lost then.
  assign sat = inc && !load && (cnt == CNT_MAX);

  // NOTE: reset is asynchronous, so rst sits in the sensitivity list and
  // clears the count without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/intc_irq_src.sv
// Interrupt source: coalesces peripheral events and requests service from
// the interrupt controller once enough events are pending.
//   clk, rst    : clock, asynchronous active-high reset
//   en          : source enable; low withdraws and blocks requests
//   event_in    : one peripheral event per cycle high
//   prio_in     : configured priority (higher = more urgent)
//   thresh      : coalescing threshold (0 behaves like 1)
//   irq_ack     : controller accepted the request (honoured only in REQ)
//   irq_eoi     : handler finished (honoured only in SERVICE)
//   clr_ovf     : clears the sticky overflow flag
//   irq_req     : request to the controller (state == REQ)
//   irq_prio    : priority latched when the request was raised
//   pending_cnt : events not yet collected by an acknowledge
//   served_cnt  : events consumed by the last acknowledge
//   overflow    : sticky, an event was lost to saturation
//   in_service  : state == SERVICE
module intc_irq_src
  import intc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             event_in,
  input  logic [CNT_W-1:0] prio_in,
  input  logic [CNT_W-1:0] thresh,
  input  logic             irq_ack,
  input  logic             irq_eoi,
  input  logic             clr_ovf,
  output logic             irq_req,
  output logic [CNT_W-1:0] irq_prio,
  output logic [CNT_W-1:0] pending_cnt,
  output logic [CNT_W-1:0] served_cnt,
  output logic             overflow,
  output logic             in_service
);

  state_t state;
  logic   load;
  logic   sat;

  // The acknowledge collects every pending event; an event arriving on the
  // same edge becomes the first event of the next batch.
  assign load = (state == ST_REQ) && irq_ack;

  intc_sat_cnt u_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc      (event_in),
    .load     (load),
    .load_val ({{(CNT_W-1){1'b0}}, event_in}),
    .cnt      (pending_cnt),
    .sat      (sat)
  );

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every branch below sees the pre-edge values, whatever the statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      irq_req    <= 1'b0;
      in_service <= 1'b0;
      irq_prio   <= '0;
      served_cnt <= '0;
      overflow   <= 1'b0;
    end else begin
      // A lost event outranks a simultaneous clear.
      if (sat) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (en && (pending_cnt >= eff_thresh(thresh))) begin
            state    <= ST_REQ;
            irq_req  <= 1'b1;
            irq_prio <= prio_in;
          end
        end
        // Threshold and priority are not re-evaluated here, so the request
        // stays stable until it is acknowledged or the source is disabled.
        ST_REQ: begin
          if (irq_ack) begin
            state      <= ST_SERVICE;
            irq_req    <= 1'b0;
            in_service <= 1'b1;
            served_cnt <= pending_cnt;
          end else if (!en) begin
            state   <= ST_IDLE;
            irq_req <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (irq_eoi) begin
            state      <= ST_IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          irq_req    <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intc_irq_src.sv
// Directed scoreboard bench for intc_irq_src. Each stimulus step pushes the
// hand-computed output vector expected after the next rising edge; a monitor
// pops and compares it 1 ns after that edge.
module tb_intc_irq_src;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, event_in, irq_ack, irq_eoi, clr_ovf;
  logic [3:0] prio_in, thresh;
  logic       irq_req, overflow, in_service;
  logic [3:0] irq_prio, pending_cnt, served_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [14:0] vec;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  intc_irq_src dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .event_in   (event_in),
    .prio_in    (prio_in),
    .thresh     (thresh),
    .irq_ack    (irq_ack),
    .irq_eoi    (irq_eoi),
    .clr_ovf    (clr_ovf),
    .irq_req    (irq_req),
    .irq_prio   (irq_prio),
    .pending_cnt(pending_cnt),
    .served_cnt (served_cnt),
    .overflow   (overflow),
    .in_service (in_service)
  );

  // {irq_req, irq_prio, pending_cnt, served_cnt, overflow, in_service}
  function automatic logic [14:0] pack(input logic r, input logic [3:0] p,
                                       input logic [3:0] pc, input logic [3:0] sc,
                                       input logic o, input logic s);
    return {r, p, pc, sc, o, s};
  endfunction

  function automatic logic [14:0] dut_vec();
    return {irq_req, irq_prio, pending_cnt, served_cnt, overflow, in_service};
  endfunction

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got req=%0b prio=%0d pend=%0d served=%0d ovf=%0b svc=%0b, want req=%0b prio=%0d pend=%0d served=%0d ovf=%0b svc=%0b",
               name, act[14], act[13:10], act[9:6], act[5:2], act[1], act[0],
               exp[14], exp[13:10], exp[9:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  // Monitor: compare the oldest expectation just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.name, dut_vec(), e.vec);
    end
  end

  // Drive one cycle of inputs on the falling edge and record the outputs
  // expected after the following rising edge.
  task automatic step(input string name, input logic e, input logic ev,
                      input logic [3:0] p, input logic [3:0] t,
                      input logic ack, input logic eoi, input logic clr,
                      input logic [14:0] exp);
    exp_t x;
    @(negedge clk);
    en = e; event_in = ev; prio_in = p; thresh = t;
    irq_ack = ack; irq_eoi = eoi; clr_ovf = clr;
    x.name = name;
    x.vec  = exp;
    sb.push_back(x);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b0; event_in = 1'b0; prio_in = '0; thresh = '0;
    irq_ack = 1'b0; irq_eoi = 1'b0; clr_ovf = 1'b0;
    #1;
    check("reset_state", dut_vec(), pack(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Coalesce three events at thresh=3; a stray ack in IDLE is ignored.
    step("evt1_ack_idle", 1, 1, 5, 3, 1, 0, 0, pack(0, 0, 1, 0, 0, 0));
    step("evt2",          1, 1, 5, 3, 0, 0, 0, pack(0, 0, 2, 0, 0, 0));
    step("evt3",          1, 1, 5, 3, 0, 0, 0, pack(0, 0, 3, 0, 0, 0));
    step("req_raise",     1, 0, 5, 3, 0, 0, 0, pack(1, 5, 3, 0, 0, 0));
    // In REQ: prio change, thresh raised above the count, stray eoi -- all ignored.
    step("req_hold",      1, 0, 9, 9, 0, 1, 0, pack(1, 5, 3, 0, 0, 0));
    step("ack1",          1, 0, 9, 3, 1, 0, 0, pack(0, 5, 0, 3, 0, 1));
    step("eoi1",          1, 0, 5, 3, 0, 1, 0, pack(0, 5, 0, 3, 0, 0));

    // Four events at thresh=4, then an event coinciding with the ack.
    step("t4_evt1",       1, 1, 5, 4, 0, 0, 0, pack(0, 5, 1, 3, 0, 0));
    step("t4_evt2",       1, 1, 5, 4, 0, 0, 0, pack(0, 5, 2, 3, 0, 0));
    step("t4_evt3",       1, 1, 5, 4, 0, 0, 0, pack(0, 5, 3, 3, 0, 0));
    step("t4_evt4",       1, 1, 5, 4, 0, 0, 0, pack(0, 5, 4, 3, 0, 0));
    step("t4_req",        1, 0, 5, 4, 0, 0, 0, pack(1, 5, 4, 3, 0, 0));
    step("ack_with_evt",  1, 1, 5, 4, 1, 0, 0, pack(0, 5, 1, 4, 0, 1));

    // 17 events in SERVICE: count 2..15, overflow from the 15th event on.
    for (int k = 1; k <= 17; k++) begin
      logic [3:0] pc;
      logic       ov;
      pc = (k >= 14) ? 4'd15 : 4'(k + 1);
      ov = (k >= 15);
      step($sformatf("svc_evt%0d", k), 1, 1, 5, 4, 0, 0, 0, pack(0, 5, pc, 4, ov, 1));
    end
    step("clr_with_evt",  1, 1, 5, 4, 0, 0, 1, pack(0, 5, 15, 4, 1, 1));
    step("clr_alone",     1, 0, 5, 4, 0, 0, 1, pack(0, 5, 15, 4, 0, 1));
    step("eoi2",          1, 0, 5, 4, 0, 1, 0, pack(0, 5, 15, 4, 0, 0));
    step("req_after_eoi", 1, 0, 7, 4, 0, 0, 0, pack(1, 7, 15, 4, 0, 0));

    // Withdraw by dropping en, then re-raise.
    step("en_drop",       0, 0, 7, 4, 0, 0, 0, pack(0, 7, 15, 4, 0, 0));
    step("en_reraise",    1, 0, 7, 4, 0, 0, 0, pack(1, 7, 15, 4, 0, 0));
    step("ack_over_en0",  0, 0, 7, 4, 1, 0, 0, pack(0, 7, 0, 15, 0, 1));

    // Reset mid-SERVICE clears everything at once; a later eoi is ignored.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_reset_svc", dut_vec(), pack(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    step("eoi_after_rst", 1, 0, 7, 4, 0, 1, 0, pack(0, 0, 0, 0, 0, 0));
    step("idle_after_rst",1, 0, 7, 4, 0, 0, 0, pack(0, 0, 0, 0, 0, 0));

    // thresh=0 behaves like 1: request one edge after the event edge.
    step("t0_evt",        1, 1, 3, 0, 0, 0, 0, pack(0, 0, 1, 0, 0, 0));
    step("t0_req",        1, 0, 3, 0, 0, 0, 0, pack(1, 3, 1, 0, 0, 0));

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
